// File: rtl/blram_arbiter.sv
// Two-port arbiter in front of a single-port block RAM with a registered read path.
// Optional build macro BLRAM_ARB_FIXED_PRIO_EN: port 0 wins every conflict (no round-robin pointer).

module blram_arbiter #(
    parameter int SIZE = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic            i_we0,
    input  logic            i_we1,
    input  logic [SIZE-1:0] i_addr0,
    input  logic [SIZE-1:0] i_addr1,
    input  logic [15:0]     i_wdata0,
    input  logic [15:0]     i_wdata1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    output logic            o_rvalid0,
    output logic            o_rvalid1,
    output logic [15:0]     o_rdata,
    output logic            o_ram_we,
    output logic [SIZE-1:0] o_ram_addr,
    output logic [15:0]     o_ram_wdata,
    input  logic [15:0]     i_ram_rdata
);

    logic            gnt0_s;
    logic            gnt1_s;
    logic            acc_s;
    logic            rd_acc_s;
    logic            cmd_we_s;
    logic [SIZE-1:0] cmd_addr_s;
    logic [15:0]     cmd_wdata_s;

    logic            ram_we_r;
    logic [SIZE-1:0] ram_addr_r;
    logic [15:0]     ram_wdata_r;

    // Owner pipeline: stage 1 matches the RAM command register, stage 2 the RAM read register.
    logic            st1_vld_r;
    logic            st1_id_r;
    logic            st2_vld_r;
    logic            st2_id_r;
    logic            rvalid0_r;
    logic            rvalid1_r;

`ifndef BLRAM_ARB_FIXED_PRIO_EN
    logic            rr_r;
`endif

    // Grant selection: lone requester always wins, conflicts resolved by priority scheme.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (i_req0 && i_req1) begin
`ifdef BLRAM_ARB_FIXED_PRIO_EN
            gnt0_s = 1'b1;
`else
            if (rr_r == 1'b0) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
`endif
        end else if (i_req0) begin
            gnt0_s = 1'b1;
        end else if (i_req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Command mux for the granted port.
    always_comb begin
        cmd_we_s    = i_we0;
        cmd_addr_s  = i_addr0;
        cmd_wdata_s = i_wdata0;
        if (gnt1_s) begin
            cmd_we_s    = i_we1;
            cmd_addr_s  = i_addr1;
            cmd_wdata_s = i_wdata1;
        end else begin
            cmd_we_s    = i_we0;
            cmd_addr_s  = i_addr0;
            cmd_wdata_s = i_wdata0;
        end
    end

    assign acc_s    = gnt0_s | gnt1_s;
    assign rd_acc_s = acc_s & ~cmd_we_s;

`ifndef BLRAM_ARB_FIXED_PRIO_EN
    // Round-robin pointer: after any grant, favour the other port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r <= 1'b0;
        end else if (gnt0_s) begin
            rr_r <= 1'b1;
        end else if (gnt1_s) begin
            rr_r <= 1'b0;
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // RAM command register; address and data hold when idle so the RAM sees a stable bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {SIZE{1'b0}};
            ram_wdata_r <= 16'h0000;
        end else if (acc_s) begin
            ram_we_r    <= cmd_we_s;
            ram_addr_r  <= cmd_addr_s;
            ram_wdata_r <= cmd_wdata_s;
        end else begin
            ram_we_r    <= 1'b0;
            ram_addr_r  <= ram_addr_r;
            ram_wdata_r <= ram_wdata_r;
        end
    end

    // Read ownership tracking; writes never enter, so only reads produce an rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st1_vld_r <= 1'b0;
            st1_id_r  <= 1'b0;
            st2_vld_r <= 1'b0;
            st2_id_r  <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            st1_vld_r <= rd_acc_s;
            st1_id_r  <= gnt1_s;
            st2_vld_r <= st1_vld_r;
            st2_id_r  <= st1_id_r;
            rvalid0_r <= st2_vld_r & ~st2_id_r;
            rvalid1_r <= st2_vld_r & st2_id_r;
        end
    end

    assign o_gnt0      = gnt0_s;
    assign o_gnt1      = gnt1_s;
    assign o_rvalid0   = rvalid0_r;
    assign o_rvalid1   = rvalid1_r;
    assign o_rdata     = i_ram_rdata;
    assign o_ram_we    = ram_we_r;
    assign o_ram_addr  = ram_addr_r;
    assign o_ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_blram_arbiter.sv
// Randomized self-checking bench for blram_arbiter against a transaction-level model
// (favoured-port bit, shadow memory, queue of expected read returns with due cycle).

module tb_blram_arbiter;

    localparam int SIZE = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_req0 = 1'b0, i_req1 = 1'b0, i_we0 = 1'b0, i_we1 = 1'b0;
    logic [SIZE-1:0] i_addr0 = '0, i_addr1 = '0;
    logic [15:0]     i_wdata0 = '0, i_wdata1 = '0;
    logic            o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_ram_we;
    logic [15:0]     o_rdata, o_ram_wdata;
    logic [SIZE-1:0] o_ram_addr;
    logic [15:0]     ram_rdata;

    always #5 clk = ~clk;

    blram_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata(o_rdata), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
    );

    // Block RAM with an input-sampling read register and an output register.
    logic [15:0] ram_mem [0:(1<<SIZE)-1] = '{default: 16'h0000};
    logic [15:0] ram_q1 = 16'h0000;
    always @(posedge clk) begin
        if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_wdata;
        ram_q1    <= ram_mem[o_ram_addr];
        ram_rdata <= ram_q1;
    end

    typedef struct {
        int          due;
        bit          port;
        logic [15:0] data;
    } rd_t;

    rd_t             rdq[$];
    logic [15:0]     shadow [0:(1<<SIZE)-1];
    int              cyc, checks, errors, last_win;
    bit              fav;
    logic            rst_nxt;
    logic            exp_we;
    logic [SIZE-1:0] exp_addr;
    logic [15:0]     exp_wdata;
    logic [49:0]     obs_v, exp_v;

    // One clock of stimulus; leaves observed and expected output vectors for the caller.
    task automatic drive_cycle(input logic r0, input logic w0, input logic [SIZE-1:0] a0,
                               input logic [15:0] d0, input logic r1, input logic w1,
                               input logic [SIZE-1:0] a1, input logic [15:0] d1);
        int win;
        bit rv0, rv1;
        logic [15:0] erd;
        @(negedge clk);
        rst = rst_nxt;
        i_req0 = r0; i_we0 = w0; i_addr0 = a0; i_wdata0 = d0;
        i_req1 = r1; i_we1 = w1; i_addr1 = a1; i_wdata1 = d1;
        #1;
        if (!rst) begin
            fav = 1'b0;
            rdq.delete();
            exp_we = 1'b0; exp_addr = '0; exp_wdata = 16'h0000;
        end
        win = -1;
        if (rst) begin
            if (r0 && r1) begin
`ifdef BLRAM_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = fav ? 1 : 0;
`endif
            end else if (r0) win = 0;
            else if (r1) win = 1;
        end
        rv0 = 1'b0; rv1 = 1'b0; erd = 16'h0000;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            if (rdq[0].port) rv1 = 1'b1; else rv0 = 1'b1;
            erd = rdq[0].data;
            void'(rdq.pop_front());
        end
        exp_v = {(win == 0), (win == 1), rv0, rv1, exp_we, exp_addr, exp_wdata, erd};
        obs_v = {o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_ram_we, o_ram_addr, o_ram_wdata,
                 (rv0 | rv1) ? o_rdata : 16'h0000};
        if (win >= 0) begin
            fav       = (win == 0);
            exp_we    = (win == 1) ? w1 : w0;
            exp_addr  = (win == 1) ? a1 : a0;
            exp_wdata = (win == 1) ? d1 : d0;
            if (exp_we) shadow[exp_addr] = exp_wdata;
            else rdq.push_back('{cyc + 3, (win == 1), shadow[exp_addr]});
        end else begin
            exp_we = 1'b0;
        end
        last_win = win;
        cyc++;
    endtask

    task automatic test_reset();
        rst_nxt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, SIZE'($urandom), 16'($urandom),
                        1'b1, 1'b1, SIZE'($urandom), 16'($urandom));
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        rst_nxt = 1'b1;
    endtask

    task automatic test_write_read();
        bit seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive_cycle(1'b1, 1'b1, 13'h0010, 16'hBEEF, 1'b0, 1'b0, 13'h0, 16'h0);
            else if (i == 1) drive_cycle(1'b1, 1'b0, 13'h0010, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
            else drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL write_read cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (i == 4 && o_rvalid0 === 1'b1 && o_rdata === 16'hBEEF) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL write_read_data got rvalid0=%b rdata=%h exp rvalid0=1 rdata=beef",
                     o_rvalid0, o_rdata);
        end
    endtask

    task automatic test_alternate();
        rst_nxt = 1'b0;
        drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
        rst_nxt = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i < 8, 1'b0, SIZE'($urandom_range(31, 0)), 16'($urandom),
                        i < 10, 1'b0, SIZE'($urandom_range(31, 0)), 16'($urandom));
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL alternate cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_cross_port();
        bit seen0 = 1'b0, seen1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b1, 13'h1FFF, 16'h1234);
            else if (i == 1) drive_cycle(1'b1, 1'b0, 13'h1FFF, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
            else drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL cross_port cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_rvalid0 === 1'b1 && o_rdata === 16'h1234) seen0 = 1'b1;
            if (o_rvalid1 !== 1'b0) seen1 = 1'b1;
        end
        checks++;
        if (!seen0 || seen1) begin
            errors++;
            $display("FAIL cross_port_data got seen0=%b seen1=%b exp seen0=1 seen1=0", seen0, seen1);
        end
    endtask

    task automatic test_idle();
        logic [SIZE-1:0] a = SIZE'($urandom);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive_cycle(1'b1, 1'b1, a, 16'($urandom), 1'b0, 1'b0, 13'h0, 16'h0);
            else if (i == 4) drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b0, a, 16'($urandom));
            else drive_cycle(1'b0, 1'b0, SIZE'($urandom), 16'h0, 1'b0, 1'b0, SIZE'($urandom), 16'h0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_flush();
        bit rv1_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rst_nxt = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            if (i == 0) drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b0, 13'h0005, 16'h0);
            else drive_cycle(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 13'h0, 16'h0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_flush cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (i > 0 && o_rvalid1 !== 1'b0) rv1_seen = 1'b1;
        end
        rst_nxt = 1'b1;
        checks++;
        if (rv1_seen) begin
            errors++;
            $display("FAIL reset_flush_rvalid1 got=1 exp=0");
        end
    endtask

    task automatic test_random();
        logic            r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0;
        logic [SIZE-1:0] a0 = '0, a1 = '0;
        logic [15:0]     d0 = '0, d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(r0 && last_win != 0)) begin
                r0 = ($urandom_range(3, 0) != 0); w0 = 1'($urandom);
                a0 = ($urandom_range(15, 0) == 0) ? 13'h1FFF : SIZE'($urandom_range(15, 0));
                d0 = 16'($urandom);
            end
            if (!(r1 && last_win != 1)) begin
                r1 = ($urandom_range(3, 0) != 0); w1 = 1'($urandom);
                a1 = SIZE'($urandom_range(15, 0));
                d1 = 16'($urandom);
            end
            if (i >= 395) begin
                r0 = 1'b0; r1 = 1'b0;
            end
            drive_cycle(r0, w0, a0, d0, r1, w1, a1, d1);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_win = -1; fav = 1'b0;
        rst_nxt = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = 16'h0000;
        rdq.delete();
        for (int i = 0; i < (1 << SIZE); i++) shadow[i] = 16'h0000;
        test_reset();
        test_write_read();
        test_alternate();
        test_cross_port();
        test_idle();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
